hslp_seq_ctrl: RTL

Sequencing controller that computes an 8x8 unsigned hybrid-approximate product by time-multiplexing one shared external 4x4 sub-multiplier over four partial-product cycles. Per quadrant (LL, LH, HL, HH) it selects high-accuracy or low-accuracy mode, then shift-accumulates the results into a 16-bit product. It replaces four parallel 4x4 units plus a final adder, trading latency for area on LUT-constrained FPGA builds. Operands enter and results leave through valid/ready handshakes.

---
 rtl/hslp_seq_ctrl_if.sv | 28 ++
 rtl/hslp_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hslp_seq_ctrl_if.sv
// Operand, shared sub-multiplier and result handshake bundle for hslp_seq_ctrl.
interface hslp_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] cfg_mode;
    logic       pp_en;
    logic [3:0] pp_a;
    logic [3:0] pp_b;
    logic       pp_hi_acc;
    logic [7:0] pp_prod;
    logic       out_valid;
    logic       out_ready;
    logic [15:0] out_prod;
    logic       out_sat;
    logic       busy;

    modport slave (
        input  in_valid, in_a, in_b, cfg_mode, pp_prod, out_ready,
        output in_ready, pp_en, pp_a, pp_b, pp_hi_acc, out_valid, out_prod, out_sat, busy
    );

    modport master (
        output in_valid, in_a, in_b, cfg_mode, pp_prod, out_ready,
        input  in_ready, pp_en, pp_a, pp_b, pp_hi_acc, out_valid, out_prod, out_sat, busy
    );
endinterface

// File: rtl/hslp_seq_ctrl.sv
// 8x8 hybrid-approximate multiplier sequencer: one shared 4x4 sub-multiplier,
// four quadrant cycles (LL, LH, HL, HH) shift-accumulated into a 17-bit sum.
module hslp_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b1,
    parameter bit SAT_EN    = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    hslp_seq_ctrl_if.slave bus
);
    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LL, S_LH, S_HL, S_HH, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [NIB_W-1:0]    mode_q, mode_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                pp_en_q, pp_en_d;
    logic [NIB_W-1:0]    pp_a_q, pp_a_d, pp_b_q, pp_b_d;
    logic                pp_hi_acc_q, pp_hi_acc_d;
    logic [PROD_W-1:0]   out_prod_q, out_prod_d;
    logic                out_sat_q, out_sat_d;
    logic [ACC_W-1:0]    pp_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pp_en_q     <= 1'b0;
            pp_a_q      <= '0;
            pp_b_q      <= '0;
            pp_hi_acc_q <= 1'b0;
            out_prod_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            pp_en_q     <= pp_en_d;
            pp_a_q      <= pp_a_d;
            pp_b_q      <= pp_b_d;
            pp_hi_acc_q <= pp_hi_acc_d;
            out_prod_q  <= out_prod_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Next state and accumulation; pp_prod is consumed in the quadrant cycle it answers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        pp_ext  = ACC_W'(bus.pp_prod);
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d    = bus.in_a;
                    b_d    = bus.in_b;
                    mode_d = bus.cfg_mode;
                    acc_d  = '0;
                    if (ZERO_SKIP && ((bus.in_a == '0) || (bus.in_b == '0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LL;
                    end
                end
            end
            S_LL: begin
                acc_d   = acc_q + pp_ext;
                state_d = S_LH;
            end
            S_LH: begin
                acc_d   = acc_q + (pp_ext << 4);
                state_d = S_HL;
            end
            S_HL: begin
                acc_d   = acc_q + (pp_ext << 4);
                state_d = S_HH;
            end
            S_HH: begin
                acc_d   = acc_q + (pp_ext << 8);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state so they line up with it.
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        pp_en_d     = 1'b0;
        pp_a_d      = '0;
        pp_b_d      = '0;
        pp_hi_acc_d = 1'b0;
        out_prod_d  = '0;
        out_sat_d   = 1'b0;
        unique case (state_d)
            S_LL: begin
                pp_en_d = 1'b1; pp_a_d = a_d[3:0]; pp_b_d = b_d[3:0]; pp_hi_acc_d = mode_d[0];
            end
            S_LH: begin
                pp_en_d = 1'b1; pp_a_d = a_d[3:0]; pp_b_d = b_d[7:4]; pp_hi_acc_d = mode_d[1];
            end
            S_HL: begin
                pp_en_d = 1'b1; pp_a_d = a_d[7:4]; pp_b_d = b_d[3:0]; pp_hi_acc_d = mode_d[2];
            end
            S_HH: begin
                pp_en_d = 1'b1; pp_a_d = a_d[7:4]; pp_b_d = b_d[7:4]; pp_hi_acc_d = mode_d[3];
            end
            S_DONE: begin
                out_sat_d  = acc_d[ACC_W-1];
                out_prod_d = (acc_d[ACC_W-1] && SAT_EN) ? {PROD_W{1'b1}} : acc_d[PROD_W-1:0];
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.pp_en     = pp_en_q;
    assign bus.pp_a      = pp_a_q;
    assign bus.pp_b      = pp_b_q;
    assign bus.pp_hi_acc = pp_hi_acc_q;
    assign bus.out_prod  = out_prod_q;
    assign bus.out_sat   = out_sat_q;
endmodule
